// File: rtl/dsram_like_responder_pkg.sv
// rtl/dsram_like_responder_pkg.sv - shared types, encodings and LFSR step for the data-memory responder
//
// Purpose : common definitions for dsram_like_responder and dsr_resp_fifo.
// Contents: size encodings, response-queue entry layout, LFSR next-state helper.

package dsram_like_responder_pkg;

    // Access size encodings carried on the size bus (informational only: lanes come from wstrb)
    localparam logic [1:0] DSR_SIZE_B = 2'd0;
    localparam logic [1:0] DSR_SIZE_H = 2'd1;
    localparam logic [1:0] DSR_SIZE_W = 2'd2;

    localparam int DSR_CNT_WD   = 4;
    localparam int DSR_ENTRY_WD = 1 + 32 + DSR_CNT_WD;

    // One outstanding transaction: kind, captured read word, cycles left until due
    typedef struct packed {
        logic                  is_wr;
        logic [31:0]           data;
        logic [DSR_CNT_WD-1:0] cnt;
    } dsr_entry_t;

    // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    function automatic logic [15:0] dsr_lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dsram_like_responder_if.sv
// rtl/dsram_like_responder_if.sv - sram-like data-memory port between CPU (master) and memory (slave)
//
// Purpose : bundles the request/response signals of the sram-like data port.
// Signals : req, wr, size[1:0], addr[31:0], wstrb[3:0], wdata[31:0]   master -> slave
//           addr_ok, data_ok, rdata[31:0]                             slave  -> master

interface dsram_like_responder_if;
    import dsram_like_responder_pkg::*;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/dsram_like_responder_resp_fifo.sv
// rtl/dsram_like_responder_resp_fifo.sv - in-order response queue with per-entry latency down-counters
//
// Purpose : holds up to MAX_OUT accepted transactions; each entry counts down from RESP_LAT-1
//           and the head becomes due once its counter reaches zero.
// Ports   : clk, rst_n                 clock, asynchronous active-low reset
//           push_i/push_is_wr_i/push_data_i   enqueue one transaction (ignored when full)
//           pop_i                      retire the head (ignored unless head is due)
//           head_due_o/head_is_wr_o/head_data_o   head state
//           full_o, count_o            occupancy (registered)

module dsr_resp_fifo
    import dsram_like_responder_pkg::*;
#(
    parameter int MAX_OUT  = 4,
    parameter int RESP_LAT = 2,
    localparam int PTR_W   = $clog2(MAX_OUT),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             push_is_wr_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    output logic             head_due_o,
    output logic             head_is_wr_o,
    output logic [31:0]      head_data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [DSR_CNT_WD-1:0] CNT_LOAD = DSR_CNT_WD'(RESP_LAT - 1);

    dsr_entry_t           ent_q [MAX_OUT];
    dsr_entry_t           ent_d [MAX_OUT];
    logic [MAX_OUT-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o       = (count_q == CNT_W'(MAX_OUT));
    assign count_o      = count_q;
    assign head_due_o   = vld_q[rd_ptr_q] && (ent_q[rd_ptr_q].cnt == '0);
    assign head_is_wr_o = ent_q[rd_ptr_q].is_wr;
    assign head_data_o  = ent_q[rd_ptr_q].data;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && head_due_o;

    always_comb begin
        ent_d    = ent_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Every entry ages each cycle; zero means "due" and stays there until the head retires it
        for (int i = 0; i < MAX_OUT; i++) begin
            if (ent_q[i].cnt != '0) begin
                ent_d[i].cnt = ent_q[i].cnt - 1'b1;
            end
        end

        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end

        // Push can never target the slot being popped: a full queue refuses the push
        if (do_push) begin
            ent_d[wr_ptr_q].is_wr = push_is_wr_i;
            ent_d[wr_ptr_q].data  = push_data_i;
            ent_d[wr_ptr_q].cnt   = CNT_LOAD;
            vld_d[wr_ptr_q]       = 1'b1;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                ent_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dsram_like_responder.sv
// rtl/dsram_like_responder.sv - sram-like data-memory responder with fixed latency and optional stalls
//
// Purpose : word-organised RAM behind the CPU data port; accepts req/addr_ok transactions and
//           returns read data / write completions in order, RESP_LAT cycles after acceptance.
// Ports   : clk      clock, all state on rising edge
//           resetn   asynchronous active-low reset (RAM contents survive it)
//           bus      slave end of dsram_like_responder_if
// Params  : DEPTH_LOG2 (RAM words = 2**DEPTH_LOG2), RESP_LAT (1..15), MAX_OUT (power of 2, >=2),
//           STALL_EN (LFSR-driven addr_ok stalls), STALL_SEED (nonzero LFSR reset value)

module dsram_like_responder
    import dsram_like_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RESP_LAT   = 2,
    parameter int          MAX_OUT    = 4,
    parameter bit          STALL_EN   = 1'b0,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    resetn,
    dsram_like_responder_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [31:0]           ram_q [DEPTH];
    logic [DEPTH_LOG2-1:0] widx;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  stall;
    logic                  full;
    logic                  accept;
    logic                  head_due;
    logic                  head_is_wr;
    logic [31:0]           head_data;
    logic [CNT_W-1:0]      count;
    logic [31:0]           push_data;
    logic                  unused_ok;

    // Upper address bits alias onto the RAM; byte offset is irrelevant for a word RAM
    assign widx = bus.addr[DEPTH_LOG2+1:2];

    // The LFSR free-runs so stall patterns are independent of traffic
    assign lfsr_d = dsr_lfsr_next(lfsr_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = STALL_EN && (lfsr_q[1:0] == 2'b00);

    // Only registered state feeds addr_ok: a retire this cycle does not reopen a full queue
    assign bus.addr_ok = resetn && !full && !stall;
    assign accept      = bus.req && bus.addr_ok;

    // Byte-lane write commits on the accepting edge
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    ram_q[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Reads capture the word at acceptance so later writes cannot disturb the returned value
    assign push_data = bus.wr ? 32'h0 : ram_q[widx];

    dsr_resp_fifo #(
        .MAX_OUT  (MAX_OUT),
        .RESP_LAT (RESP_LAT)
    ) u_resp_fifo (
        .clk          (clk),
        .rst_n        (resetn),
        .push_i       (accept),
        .push_is_wr_i (bus.wr),
        .push_data_i  (push_data),
        .pop_i        (head_due),
        .head_due_o   (head_due),
        .head_is_wr_o (head_is_wr),
        .head_data_o  (head_data),
        .full_o       (full),
        .count_o      (count)
    );

    // No backpressure on responses: a due head retires in the same cycle it is presented
    assign bus.data_ok = head_due;
    assign bus.rdata   = (head_due && !head_is_wr) ? head_data : 32'h0;

    assign unused_ok = ^{bus.size, bus.addr[1:0], bus.addr[31:DEPTH_LOG2+2], count};

endmodule

// File: tb/tb_dsram_like_responder.sv
// tb/tb_dsram_like_responder.sv - scoreboard bench for dsram_like_responder

module tb_dsram_like_responder;
    import dsram_like_responder_pkg::*;

    localparam int LAT_A   = 2;
    localparam int LAT_B   = 8;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    dsram_like_responder_if bus_a();
    dsram_like_responder_if bus_b();

    dsram_like_responder #(
        .DEPTH_LOG2 (12), .RESP_LAT (LAT_A), .MAX_OUT (MAX_OUT),
        .STALL_EN (1'b0), .STALL_SEED (16'hACE1)
    ) u_dut_a (
        .clk (clk), .resetn (rst_a_n), .bus (bus_a)
    );

    dsram_like_responder #(
        .DEPTH_LOG2 (12), .RESP_LAT (LAT_B), .MAX_OUT (MAX_OUT),
        .STALL_EN (1'b1), .STALL_SEED (16'hACE1)
    ) u_dut_b (
        .clk (clk), .resetn (rst_b_n), .bus (bus_b)
    );

    logic [31:0] exp_a_q[$];
    int          due_a_q[$];
    logic [31:0] exp_b_q[$];
    int          due_b_q[$];
    logic [31:0] gold_b[int];

    int out_b        = 0;
    int max_out_b    = 0;
    int nf_cycles    = 0;
    int stall_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    // Drive one request from posedge+1 and hold it until accepted; expected response is queued
    task automatic issue_a(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        bus_a.req = 1'b1; bus_a.wr = w; bus_a.addr = a; bus_a.wstrb = s;
        bus_a.wdata = d; bus_a.size = DSR_SIZE_W;
        while (!bus_a.addr_ok && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus_a.addr_ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_a timeout addr %08h: got addr_ok 0 expected 1", a);
        end else begin
            exp_a_q.push_back(w ? 32'h0 : e);
            due_a_q.push_back(cyc + LAT_A);
        end
        @(posedge clk); #1;
        bus_a.req = 1'b0;
    endtask

    task automatic issue_b(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
        int          n = 0;
        int          idx;
        logic [31:0] v;
        bus_b.req = 1'b1; bus_b.wr = w; bus_b.addr = a; bus_b.wstrb = s;
        bus_b.wdata = d; bus_b.size = DSR_SIZE_W;
        while (!bus_b.addr_ok && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus_b.addr_ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_b timeout addr %08h: got addr_ok 0 expected 1", a);
        end else begin
            idx = int'(a[13:2]);
            v   = gold_b.exists(idx) ? gold_b[idx] : 32'h0;
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) v[8*i +: 8] = d[8*i +: 8];
                end
                gold_b[idx] = v;
                exp_b_q.push_back(32'h0);
            end else begin
                exp_b_q.push_back(v);
            end
            due_b_q.push_back(cyc + LAT_B);
        end
        @(posedge clk); #1;
        bus_b.req = 1'b0;
    endtask

    // Monitor A: pops on every data_ok, checks data and exact latency
    always @(negedge clk) begin : mon_a
        int d;
        if (bus_a.data_ok) begin
            if (exp_a_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL data_ok_a unexpected at cycle %0d: got 1 expected 0", cyc);
            end else begin
                check("rdata_a", bus_a.rdata, exp_a_q.pop_front());
                d = due_a_q.pop_front();
                check("latency_a", 32'(cyc), 32'(d));
            end
        end else begin
            check("rdata_idle_a", bus_a.rdata, 32'h0);
            if (due_a_q.size() != 0 && due_a_q[0] <= cyc) begin
                vectors++; miscompares++;
                $display("FAIL missing_data_ok_a at cycle %0d: got 0 expected 1", cyc);
                void'(due_a_q.pop_front());
                void'(exp_a_q.pop_front());
            end
        end
    end

    // Monitor B: scoreboard plus occupancy bound and stall statistics
    always @(negedge clk) begin : mon_b
        int d;
        if (!rst_b_n) begin
            out_b = 0;
            check("data_ok_rst_b", {31'h0, bus_b.data_ok}, 32'h0);
        end else begin
            if (out_b == MAX_OUT) begin
                check("addr_ok_full_b", {31'h0, bus_b.addr_ok}, 32'h0);
            end else begin
                nf_cycles++;
                if (!bus_b.addr_ok) stall_cycles++;
            end
            if (bus_b.data_ok) begin
                if (exp_b_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL data_ok_b unexpected at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    check("rdata_b", bus_b.rdata, exp_b_q.pop_front());
                    d = due_b_q.pop_front();
                    check("latency_b", 32'(cyc), 32'(d));
                end
            end else begin
                check("rdata_idle_b", bus_b.rdata, 32'h0);
                if (due_b_q.size() != 0 && due_b_q[0] <= cyc) begin
                    vectors++; miscompares++;
                    $display("FAIL missing_data_ok_b at cycle %0d: got 0 expected 1", cyc);
                    void'(due_b_q.pop_front());
                    void'(exp_b_q.pop_front());
                end
            end
            out_b = out_b + int'(bus_b.req && bus_b.addr_ok) - int'(bus_b.data_ok);
            if (out_b > max_out_b) max_out_b = out_b;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = DSR_SIZE_W; bus_a.addr = '0;
        bus_a.wstrb = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = DSR_SIZE_W; bus_b.addr = '0;
        bus_b.wstrb = '0; bus_b.wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("addr_ok_rst_a", {31'h0, bus_a.addr_ok}, 32'h0);
        check("data_ok_rst_a", {31'h0, bus_a.data_ok}, 32'h0);
        check("addr_ok_rst_b", {31'h0, bus_b.addr_ok}, 32'h0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(posedge clk); #1;
        check("addr_ok_idle_a", {31'h0, bus_a.addr_ok}, 32'h1);

        // Write then read on consecutive edges
        issue_a(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
        issue_a(1'b0, 32'h10, 4'hF, 32'h0,        32'hDEADBEEF);
        repeat (3) @(posedge clk); #1;
        // Byte strobes
        issue_a(1'b1, 32'h20, 4'hF,    32'h11223344, 32'h0);
        issue_a(1'b1, 32'h20, 4'b0010, 32'h0000AA00, 32'h0);
        issue_a(1'b0, 32'h20, 4'hF,    32'h0,        32'h1122AA44);
        issue_a(1'b1, 32'h24, 4'hF,    32'h00000000, 32'h0);
        issue_a(1'b1, 32'h24, 4'b0001, 32'h000000CC, 32'h0);
        issue_a(1'b1, 32'h24, 4'b1000, 32'hBB000000, 32'h0);
        issue_a(1'b1, 32'h24, 4'b0000, 32'hFFFFFFFF, 32'h0);
        issue_a(1'b0, 32'h24, 4'hF,    32'h0,        32'hBB0000CC);
        issue_a(1'b1, 32'h24, 4'b0110, 32'h12345678, 32'h0);
        issue_a(1'b0, 32'h24, 4'hF,    32'h0,        32'hBB3456CC);
        repeat (3) @(posedge clk); #1;
        // Read captures data before the following write
        issue_a(1'b1, 32'h30, 4'hF, 32'h5, 32'h0);
        repeat (3) @(posedge clk); #1;
        issue_a(1'b0, 32'h30, 4'hF, 32'h0, 32'h5);
        issue_a(1'b1, 32'h30, 4'hF, 32'h9, 32'h0);
        issue_a(1'b0, 32'h30, 4'hF, 32'h0, 32'h9);
        // Address aliasing, ignored byte offset, last word
        issue_a(1'b1, 32'h4010, 4'hF, 32'hCAFEF00D, 32'h0);
        issue_a(1'b0, 32'h10,   4'hF, 32'h0,        32'hCAFEF00D);
        issue_a(1'b0, 32'h13,   4'hF, 32'h0,        32'hCAFEF00D);
        issue_a(1'b1, 32'h3FFC, 4'hF, 32'h0BADC0DE, 32'h0);
        issue_a(1'b0, 32'h7FFC, 4'hF, 32'h0,        32'h0BADC0DE);
        repeat (5) @(posedge clk); #1;
        issue_a(1'b0, 32'h20, 4'hF, 32'h0, 32'h1122AA44);

        // Instance B: initialise a 16-word window
        for (int k = 0; k < 16; k++) begin
            issue_b(1'b1, 32'h100 + 32'(4 * k), 4'hF, $urandom);
        end
        // Requests held every cycle: occupancy must saturate at MAX_OUT
        for (int k = 0; k < 12; k++) begin
            issue_b(1'b0, 32'h100 + 32'(4 * (k % 16)), 4'hF, 32'h0);
        end
        repeat (12) @(posedge clk); #1;

        // Reset with three reads outstanding: their responses must vanish
        issue_b(1'b0, 32'h100, 4'hF, 32'h0);
        issue_b(1'b0, 32'h104, 4'hF, 32'h0);
        issue_b(1'b0, 32'h108, 4'hF, 32'h0);
        rst_b_n = 1'b0;
        exp_b_q.delete();
        due_b_q.delete();
        #1;
        check("addr_ok_midrst_b", {31'h0, bus_b.addr_ok}, 32'h0);
        check("rdata_midrst_b", bus_b.rdata, 32'h0);
        repeat (3) @(posedge clk); #1;
        rst_b_n = 1'b1;
        repeat (12) @(posedge clk); #1;
        issue_b(1'b0, 32'h104, 4'hF, 32'h0);

        // Random traffic against the golden memory, with stalls enabled
        for (int k = 0; k < 1000; k++) begin
            logic w;
            w = 1'($urandom_range(0, 1));
            issue_b(w, 32'h100 + 32'(4 * $urandom_range(0, 15)),
                    w ? 4'($urandom_range(0, 15)) : 4'hF, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 200 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("drain_a", 32'(exp_a_q.size()), 32'h0);
        check("drain_b", 32'(exp_b_q.size()), 32'h0);
        check("max_outstanding_b", 32'(max_out_b), 32'(MAX_OUT));
        check("stall_fraction_b",
              {31'h0, (stall_cycles * 100 >= nf_cycles * 15) && (stall_cycles * 100 <= nf_cycles * 35)},
              32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
